// File: rtl/mips32.sv
// Single-cycle MIPS32 integer datapath: combinational ALU result from the
// externally applied instruction, written back to a 32-entry register file.
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;

    logic [DATA_W-1:0] registers [0:NUM_REGS-1];

    // $0 is hardwired to zero on the read side as well as the write side
    assign rdata1 = (raddr1 == 5'd0) ? '0 : registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : registers[raddr2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end
endmodule

module mips32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [31:0] result
);
    localparam int unsigned DATA_W = 32;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] for_sltu_operation;
    logic [4:0]        waddr;
    logic              we;

    assign opcode   = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign imm      = instruction[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    register_file register (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (for_sltu_operation),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val)
    );

    // Decode and execute; unsupported encodings yield zero and no write
    always_comb begin
        for_sltu_operation = '0;
        we                 = 1'b0;
        waddr              = rd;
        if (opcode == 6'h00) begin
            we    = 1'b1;
            waddr = rd;
            case (funct)
                6'h20, 6'h21: for_sltu_operation = rs_val + rt_val;
                6'h22, 6'h23: for_sltu_operation = rs_val - rt_val;
                6'h24:        for_sltu_operation = rs_val & rt_val;
                6'h25:        for_sltu_operation = rs_val | rt_val;
                6'h26:        for_sltu_operation = rs_val ^ rt_val;
                6'h27:        for_sltu_operation = ~(rs_val | rt_val);
                6'h2A:        for_sltu_operation = DATA_W'($signed(rs_val) < $signed(rt_val));
                6'h2B:        for_sltu_operation = DATA_W'(rs_val < rt_val);
                6'h00:        for_sltu_operation = rt_val << shamt;
                6'h02:        for_sltu_operation = rt_val >> shamt;
                6'h03:        for_sltu_operation = DATA_W'($signed(rt_val) >>> shamt);
                default:      we = 1'b0;
            endcase
        end else begin
            we    = 1'b1;
            waddr = rt;
            case (opcode)
                6'h08, 6'h09: for_sltu_operation = rs_val + imm_sext;
                6'h0A:        for_sltu_operation = DATA_W'($signed(rs_val) < $signed(imm_sext));
                6'h0B:        for_sltu_operation = DATA_W'(rs_val < imm_sext);
                6'h0C:        for_sltu_operation = rs_val & imm_zext;
                6'h0D:        for_sltu_operation = rs_val | imm_zext;
                6'h0E:        for_sltu_operation = rs_val ^ imm_zext;
                6'h0F:        for_sltu_operation = {imm, 16'h0000};
                default:      we = 1'b0;
            endcase
        end
    end

    assign result = for_sltu_operation;
endmodule

// File: tb/tb_mips32.sv
// Directed self-checking bench for mips32: instructions are applied at the
// falling edge, results sampled mid-cycle, register state after rising edges.
module tb_mips32;
    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] result;
    int          checks;
    int          errors;
    logic        all_zero;

    mips32 dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply at the falling edge so the next rising edge performs exactly one write
    task automatic apply(input logic [31:0] instr);
        @(negedge clk);
        instruction = instr;
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        instruction = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_reg1", dut.register.registers[1], 32'h0);
        chk("reset_result", result, 32'h0);

        apply(itype(6'h08, 5'd0, 5'd1, 16'd5));
        chk("addi_load1", result, 32'd5);
        apply(itype(6'h08, 5'd0, 5'd2, 16'd7));
        chk("addi_load2", result, 32'd7);
        apply(32'h00221820);
        chk("add_result", result, 32'd12);
        chk("probe_net", dut.for_sltu_operation, 32'd12);
        apply(32'h0);
        chk("nop_result", result, 32'h0);
        chk("add_wb", dut.register.registers[3], 32'd12);

        apply(itype(6'h08, 5'd0, 5'd1, 16'hFFFF));
        chk("addi_neg", result, 32'hFFFFFFFF);
        apply(itype(6'h08, 5'd0, 5'd2, 16'd1));
        apply(32'h0022202B);
        chk("sltu", result, 32'd0);
        apply(32'h0022202A);
        chk("slt", result, 32'd1);
        apply(rtype(5'd0, 5'd1, 5'd10, 5'd0, 6'h22));
        chk("sub_wrap", result, 32'd1);
        apply(rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h27));
        chk("nor", result, 32'hFFFFFFFF);
        apply(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h21));
        chk("addu_wrap", result, 32'h0);

        apply(itype(6'h0D, 5'd0, 5'd5, 16'hF0F0));
        chk("ori", result, 32'h0000F0F0);
        apply(itype(6'h0F, 5'd0, 5'd6, 16'h1234));
        chk("lui", result, 32'h12340000);
        apply(itype(6'h08, 5'd0, 5'd7, 16'hFFFF));
        chk("addi_m1", result, 32'hFFFFFFFF);
        apply(itype(6'h0B, 5'd0, 5'd9, 16'hFFFF));
        chk("sltiu_sext", result, 32'd1);
        apply(itype(6'h0A, 5'd7, 5'd9, 16'd0));
        chk("slti", result, 32'd1);
        apply(itype(6'h0C, 5'd7, 5'd9, 16'h8001));
        chk("andi_zext", result, 32'h00008001);
        apply(itype(6'h0E, 5'd7, 5'd9, 16'hFFFF));
        chk("xori_zext", result, 32'hFFFF0000);

        apply(itype(6'h0F, 5'd0, 5'd2, 16'h8000));
        chk("lui_msb", result, 32'h80000000);
        apply(rtype(5'd0, 5'd2, 5'd8, 5'd4, 6'h03));
        chk("sra", result, 32'hF8000000);
        apply(rtype(5'd0, 5'd2, 5'd8, 5'd4, 6'h02));
        chk("srl", result, 32'h08000000);
        apply(rtype(5'd0, 5'd2, 5'd8, 5'd1, 6'h00));
        chk("sll", result, 32'h0);

        apply(itype(6'h08, 5'd0, 5'd0, 16'd9));
        chk("addi_r0_result", result, 32'd9);
        apply(rtype(5'd0, 5'd0, 5'd11, 5'd0, 6'h25));
        chk("r0_reads_zero", result, 32'h0);
        chk("r0_storage", dut.register.registers[0], 32'h0);

        apply(itype(6'h08, 5'd0, 5'd1, 16'd1));
        apply(itype(6'h08, 5'd0, 5'd2, 16'd1));
        apply(rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h20));
        chk("rmw_first", result, 32'd2);
        @(posedge clk);
        #1;
        chk("rmw_after1", dut.register.registers[1], 32'd2);
        chk("no_writethru", result, 32'd3);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rmw_after3", dut.register.registers[1], 32'd4);

        apply(32'hFC221820);
        chk("bad_opcode", result, 32'h0);
        apply(rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h3F));
        chk("bad_funct", result, 32'h0);
        apply(32'h0);
        chk("bad_nowrite", dut.register.registers[1], 32'd4);

        apply(itype(6'h08, 5'd0, 5'd3, 16'd9));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        all_zero = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (dut.register.registers[i] !== 32'h0) all_zero = 1'b0;
        end
        chk("reset_clears_all", {31'h0, all_zero}, 32'd1);
        chk("reset_suppress", dut.register.registers[3], 32'h0);
        apply(32'h00221820);
        chk("add_after_reset", result, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips32.md
MIPS32 -- requirements
Module: mips32

Interface
REQ-001 No parameters; register count fixed at 32, data width fixed at 32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instruction  input  32  MIPS32 instruction word, driven externally; no PC and no instruction memory inside the block.
REQ-005 result  output  32  combinational result of the current instruction.
REQ-006 Register file SHALL be a sub-instance named "register" holding array "registers[0:31]" of 32-bit words, so a bench can preload and dump it via $readmemb/$writememb.
REQ-007 The internal net "for_sltu_operation" (32 bit) SHALL carry the same value as result, so a bench can probe it hierarchically.

Function
REQ-008 Decode: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
REQ-009 R-type (opcode 0x00), write rd, selected by funct: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu (unsigned), 0x00 sll, 0x02 srl, 0x03 sra.
REQ-010 Shifts: operand rt, amount shamt; sra replicates bit 31.
REQ-011 I-type, write rt: 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui.
REQ-012 imm sign-extended for addi/addiu/slti/sltiu; zero-extended for andi/ori/xori; lui result = {imm,16'h0000}.
REQ-013 slt/slti/sltu/sltiu results are 32'd1 when true, 32'd0 when false; sltiu compares the sign-extended imm as unsigned.
REQ-014 Add/sub wrap modulo 2^32; no overflow trap or flag for any opcode.
REQ-015 result SHALL be combinational: a function of instruction and current register contents only; valid in the same cycle the instruction is applied.
REQ-016 Register write SHALL occur on each rising clk edge while reset=0 and the instruction is supported; the written value equals result.
REQ-017 An instruction held across N clock edges SHALL write N times; read-modify-write forms (e.g. add $1,$1,$2) therefore accumulate once per edge.
REQ-018 Register $0 SHALL always read 0; writes to $0 are discarded.
REQ-019 Register reads SHALL return the pre-edge value; the new value is visible after the edge (no write-through).
REQ-020 Unsupported opcode/funct: result = 0, no register write.
REQ-021 instruction = 32'h00000000 (sll $0,$0,0) SHALL produce result 0 and change no state.

Reset
REQ-022 reset=1 at a rising clk edge SHALL clear all 32 registers to 0 and suppress the write of the current instruction.
REQ-023 result is not reset directly; it follows REQ-015 from the cleared registers.
REQ-024 Without an asserted reset, register contents preloaded via hierarchy SHALL be preserved until written.

Verification
REQ-025 $1=5, $2=7; add $3,$1,$2 (0x00221820) -> result 12; after edge $3=12.
REQ-026 $1=0xFFFFFFFF, $2=1; sltu $4,$1,$2 (0x0022202B) -> result 0; slt $4,$1,$2 (0x0022202A) -> result 1.
REQ-027 ori $5,$0,0xF0F0 -> result 0x0000F0F0; lui $6,0x1234 -> 0x12340000; addi $7,$0,-1 -> 0xFFFFFFFF.
REQ-028 $2=0x80000000; sra $8,$2,4 -> 0xF8000000; srl $8,$2,4 -> 0x08000000; sll $8,$2,1 -> 0.
REQ-029 addi $0,$0,9 -> result 9, $0 remains 0; hold add $1,$1,$2 ($1=1,$2=1) for 3 edges -> $1=4.
REQ-030 Preload registers nonzero, assert reset one edge -> all registers 0; add $3,$1,$2 -> result 0.
